// File: rtl/vending_machine_core.sv
// Coin-operated vending controller: quarter/dollar credit with a cap, three
// priced items, refund, and one-cycle dispense/change/message pulses.
module vending_machine_core #(
  parameter int PRICE_1 = 2,
  parameter int PRICE_2 = 6,
  parameter int PRICE_3 = 10,
  parameter int MAX_AMT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_quarter,
  input  logic       i_dollar,
  input  logic [3:0] i_buttons,
  output logic [3:0] o_item,
  output logic [4:0] o_amt,
  output logic [4:0] o_change,
  output logic       o_msg_en
);

  typedef enum logic [1:0] {IDLE, VEND, REFUND, DENY} state_t;

  localparam logic [4:0] P1  = 5'(PRICE_1);
  localparam logic [4:0] P2  = 5'(PRICE_2);
  localparam logic [4:0] P3  = 5'(PRICE_3);
  localparam logic [4:0] MAX = 5'(MAX_AMT);

  state_t     state, state_nx;
  logic       q_r, d_r;
  logic [3:0] btn_r;
  logic [4:0] credit, credit_nx, change_nx, price;
  logic [3:0] item_nx;
  logic       msg_nx;
  logic       q_ev, d_ev;
  logic [3:0] btn_ev;

  assign q_ev   = i_quarter & ~q_r;
  assign d_ev   = i_dollar & ~d_r;
  assign btn_ev = i_buttons & ~btn_r;

  always_comb begin
    state_nx  = IDLE;
    credit_nx = credit;
    change_nx = 5'd0;
    item_nx   = 4'd0;
    msg_nx    = 1'b0;
    price     = P3;
    // Buttons only act from IDLE and only when no coin arrives alongside.
    if (state == IDLE && !q_ev && !d_ev && $onehot(btn_ev)) begin
      if (btn_ev[0]) begin
        state_nx  = REFUND;
        change_nx = credit;
        credit_nx = 5'd0;
      end else begin
        if (btn_ev[1])      price = P1;
        else if (btn_ev[2]) price = P2;
        if (credit >= price) begin
          state_nx  = VEND;
          item_nx   = btn_ev;
          change_nx = credit - price;
          credit_nx = 5'd0;
        end else begin
          state_nx = DENY;
          msg_nx   = 1'b1;
        end
      end
    end
    // Cap test written as credit <= MAX-value so the 5-bit sum never wraps.
    if (q_ev) begin
      if (credit_nx <= MAX - 5'd1) credit_nx = credit_nx + 5'd1;
      else begin
        change_nx = change_nx + 5'd1;
        msg_nx    = 1'b1;
      end
    end
    if (d_ev) begin
      if (credit_nx <= MAX - 5'd4) credit_nx = credit_nx + 5'd4;
      else begin
        change_nx = change_nx + 5'd4;
        msg_nx    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      credit   <= 5'd0;
      q_r      <= 1'b0;
      d_r      <= 1'b0;
      btn_r    <= 4'd0;
      o_item   <= 4'd0;
      o_change <= 5'd0;
      o_msg_en <= 1'b0;
    end else begin
      state    <= state_nx;
      credit   <= credit_nx;
      q_r      <= i_quarter;
      d_r      <= i_dollar;
      btn_r    <= i_buttons;
      o_item   <= item_nx;
      o_change <= change_nx;
      o_msg_en <= msg_nx;
    end
  end

  assign o_amt = credit;

endmodule

// File: tb/tb_vending_machine_core.sv
// Directed bench for vending_machine_core with hand-computed expectations.
module tb_vending_machine_core;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_quarter, i_dollar;
  logic [3:0] i_buttons;
  logic [3:0] o_item;
  logic [4:0] o_amt, o_change;
  logic       o_msg_en;
  int errors = 0;
  int checks = 0;

  vending_machine_core dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_quarter(i_quarter), .i_dollar(i_dollar),
    .i_buttons(i_buttons), .o_item(o_item), .o_amt(o_amt), .o_change(o_change),
    .o_msg_en(o_msg_en)
  );

  always #5 i_clk = ~i_clk;

  // Packed observation: {item, amt, change, msg}
  logic [14:0] obs;
  assign obs = {o_item, o_amt, o_change, o_msg_en};

  function automatic logic [14:0] ev(input logic [3:0] item, input logic [4:0] amt,
                                     input logic [4:0] chg, input logic msg);
    return {item, amt, chg, msg};
  endfunction

  task automatic apply(input logic q, input logic d, input logic [3:0] b);
    @(negedge i_clk);
    i_quarter = q; i_dollar = d; i_buttons = b;
    @(posedge i_clk); #1;
  endtask

  task automatic rel();
    apply(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_quarter = 1'b0; i_dollar = 1'b0; i_buttons = 4'd0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd0, 1'b0)) begin errors++; $display("FAIL reset_state got %h want %h", obs, ev(4'd0, 5'd0, 5'd0, 1'b0)); end
    @(negedge i_clk); i_rst_n = 1'b1;
  endtask

  task automatic test_item1();
    apply(1, 0, 0);
    checks++; if (obs !== ev(4'd0, 5'd1, 5'd0, 1'b0)) begin errors++; $display("FAIL i1_q1 got %h want %h", obs, ev(4'd0, 5'd1, 5'd0, 1'b0)); end
    rel(); apply(1, 0, 0);
    checks++; if (obs !== ev(4'd0, 5'd2, 5'd0, 1'b0)) begin errors++; $display("FAIL i1_q2 got %h want %h", obs, ev(4'd0, 5'd2, 5'd0, 1'b0)); end
    rel(); apply(0, 0, 4'b0010);
    checks++; if (obs !== ev(4'b0010, 5'd0, 5'd0, 1'b0)) begin errors++; $display("FAIL i1_vend got %h want %h", obs, ev(4'b0010, 5'd0, 5'd0, 1'b0)); end
    rel();
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd0, 1'b0)) begin errors++; $display("FAIL i1_after got %h want %h", obs, ev(4'd0, 5'd0, 5'd0, 1'b0)); end
  endtask

  task automatic test_item2_change();
    apply(1, 0, 0); rel(); apply(1, 0, 0); rel();
    apply(0, 1, 0);
    checks++; if (obs !== ev(4'd0, 5'd6, 5'd0, 1'b0)) begin errors++; $display("FAIL i2_dollar got %h want %h", obs, ev(4'd0, 5'd6, 5'd0, 1'b0)); end
    rel(); apply(1, 0, 0);
    checks++; if (obs !== ev(4'd0, 5'd7, 5'd0, 1'b0)) begin errors++; $display("FAIL i2_amt7 got %h want %h", obs, ev(4'd0, 5'd7, 5'd0, 1'b0)); end
    rel(); apply(0, 0, 4'b0100);
    checks++; if (obs !== ev(4'b0100, 5'd0, 5'd1, 1'b0)) begin errors++; $display("FAIL i2_vend got %h want %h", obs, ev(4'b0100, 5'd0, 5'd1, 1'b0)); end
    rel();
  endtask

  task automatic test_cap();
    for (int k = 1; k <= 4; k++) begin
      apply(0, 1, 0);
      checks++; if (o_amt !== 5'(4 * k)) begin errors++; $display("FAIL cap_amt%0d got %0d want %0d", k, o_amt, 4 * k); end
      rel();
    end
    apply(0, 1, 0);
    checks++; if (obs !== ev(4'd0, 5'd16, 5'd4, 1'b1)) begin errors++; $display("FAIL cap_reject got %h want %h", obs, ev(4'd0, 5'd16, 5'd4, 1'b1)); end
    rel();
    checks++; if (obs !== ev(4'd0, 5'd16, 5'd0, 1'b0)) begin errors++; $display("FAIL cap_msg_clear got %h want %h", obs, ev(4'd0, 5'd16, 5'd0, 1'b0)); end
    apply(0, 0, 4'b1000);
    checks++; if (obs !== ev(4'b1000, 5'd0, 5'd6, 1'b0)) begin errors++; $display("FAIL cap_vend3 got %h want %h", obs, ev(4'b1000, 5'd0, 5'd6, 1'b0)); end
    rel();
  endtask

  task automatic test_refund();
    apply(1, 0, 0); rel(); apply(1, 0, 0); rel(); apply(0, 1, 0); rel(); apply(1, 0, 0); rel();
    apply(0, 0, 4'b0001);
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd7, 1'b0)) begin errors++; $display("FAIL refund got %h want %h", obs, ev(4'd0, 5'd0, 5'd7, 1'b0)); end
    rel();
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd0, 1'b0)) begin errors++; $display("FAIL refund_after got %h want %h", obs, ev(4'd0, 5'd0, 5'd0, 1'b0)); end
    apply(0, 0, 4'b0001);
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd0, 1'b0)) begin errors++; $display("FAIL refund_zero got %h want %h", obs, ev(4'd0, 5'd0, 5'd0, 1'b0)); end
    rel();
  endtask

  task automatic test_deny();
    apply(1, 0, 0); rel(); apply(1, 0, 0); rel();
    apply(0, 0, 4'b0100);
    checks++; if (obs !== ev(4'd0, 5'd2, 5'd0, 1'b1)) begin errors++; $display("FAIL deny got %h want %h", obs, ev(4'd0, 5'd2, 5'd0, 1'b1)); end
    rel();
    checks++; if (obs !== ev(4'd0, 5'd2, 5'd0, 1'b0)) begin errors++; $display("FAIL deny_after got %h want %h", obs, ev(4'd0, 5'd2, 5'd0, 1'b0)); end
    apply(0, 0, 4'b0001); rel();
  endtask

  task automatic test_coincident();
    apply(0, 1, 0); rel(); apply(0, 1, 0); rel(); apply(0, 1, 0); rel();
    apply(1, 0, 0); rel(); apply(1, 0, 0); rel();
    apply(1, 1, 0);
    checks++; if (obs !== ev(4'd0, 5'd15, 5'd4, 1'b1)) begin errors++; $display("FAIL qd_same got %h want %h", obs, ev(4'd0, 5'd15, 5'd4, 1'b1)); end
    rel(); apply(0, 0, 4'b0001);
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd15, 1'b0)) begin errors++; $display("FAIL qd_refund got %h want %h", obs, ev(4'd0, 5'd0, 5'd15, 1'b0)); end
    rel();
    apply(1, 0, 0); rel(); apply(1, 0, 0); rel();
    apply(1, 0, 4'b0010);
    checks++; if (obs !== ev(4'd0, 5'd3, 5'd0, 1'b0)) begin errors++; $display("FAIL coin_btn got %h want %h", obs, ev(4'd0, 5'd3, 5'd0, 1'b0)); end
    rel(); apply(0, 0, 4'b0110);
    checks++; if (obs !== ev(4'd0, 5'd3, 5'd0, 1'b0)) begin errors++; $display("FAIL not_onehot got %h want %h", obs, ev(4'd0, 5'd3, 5'd0, 1'b0)); end
    rel(); apply(0, 0, 4'b0010);
    checks++; if (obs !== ev(4'b0010, 5'd0, 5'd1, 1'b0)) begin errors++; $display("FAIL vend_q3 got %h want %h", obs, ev(4'b0010, 5'd0, 5'd1, 1'b0)); end
    apply(1, 0, 4'b1000);
    checks++; if (obs !== ev(4'd0, 5'd1, 5'd0, 1'b0)) begin errors++; $display("FAIL coin_in_vend got %h want %h", obs, ev(4'd0, 5'd1, 5'd0, 1'b0)); end
    rel(); apply(0, 0, 4'b0001); rel();
  endtask

  task automatic test_held();
    apply(1, 0, 0); apply(1, 0, 0); apply(1, 0, 0);
    checks++; if (o_amt !== 5'd1) begin errors++; $display("FAIL held_once got %0d want 1", o_amt); end
    rel(); apply(0, 0, 4'b0001); rel();
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 0); rel(); apply(1, 0, 0); rel(); apply(1, 0, 0);
    checks++; if (o_amt !== 5'd3) begin errors++; $display("FAIL rm_pre got %0d want 3", o_amt); end
    @(negedge i_clk); i_quarter = 1'b0; i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd0, 1'b0)) begin errors++; $display("FAIL rm_reset got %h want %h", obs, ev(4'd0, 5'd0, 5'd0, 1'b0)); end
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (obs !== ev(4'd0, 5'd0, 5'd0, 1'b0)) begin errors++; $display("FAIL rm_after got %h want %h", obs, ev(4'd0, 5'd0, 5'd0, 1'b0)); end
    // Quarter held through reset release yields exactly one event.
    @(negedge i_clk); i_rst_n = 1'b0; i_quarter = 1'b1;
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_amt !== 5'd1) begin errors++; $display("FAIL rm_held got %0d want 1", o_amt); end
    @(posedge i_clk); #1;
    checks++; if (o_amt !== 5'd1) begin errors++; $display("FAIL rm_held2 got %0d want 1", o_amt); end
    rel();
  endtask

  initial begin
    test_reset();
    test_item1();
    test_item2_change();
    test_cap();
    test_refund();
    test_deny();
    test_coincident();
    test_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
